// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the next-PC sequencer.
// The FSM states, the sequential PC step, and the sizing helper for the flush counter.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam int unsigned PC_INCR = 4;

  // The counter only ever holds FLUSH_CYCLES-1, so it never needs more than one bit below two
  function automatic int flush_cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pc_flush_timer.sv
// Flush-window down-counter: loads on a redirect and steps down on unstalled flush cycles.
// done_o means the current decrement is the last one, so the FSM leaves FLUSH on that edge.
module pc_flush_timer
  import pc_seq_pkg::*;
#(
  parameter int CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int W = flush_cnt_width(CYCLES);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = W'(CYCLES - 1);
    else if (dec_i && (count_q != '0))
      count_d = count_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign done_o = (count_q <= W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks the PC register input and write enable, and drives the flush window.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect targets go to TRAP_VECTOR).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int             XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int             FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(64'h100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_cur,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_we,
  output logic            flush,
  output logic            halted,
  output logic            trap
);

  state_e state_q, state_d;

  logic            timer_load, timer_dec, timer_done;
  logic            redirect;
  logic [XLEN-1:0] redir_target, redir_pc, pc_seq;
  logic            redir_trap;

  pc_flush_timer #(
    .CYCLES (FLUSH_CYCLES)
  ) u_flush_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (timer_load),
    .dec_i  (timer_dec),
    .done_o (timer_done)
  );

  assign redirect     = jump | branch_taken;
  assign redir_target = jump ? jump_target : branch_target;
  assign pc_seq       = pc_cur + XLEN'(PC_INCR);

`ifdef PC_MISALIGN_TRAP_EN
  assign redir_trap = (redir_target[1:0] != 2'b00);
  assign redir_pc   = redir_trap ? TRAP_VECTOR : redir_target;
`else
  assign redir_trap = 1'b0;
  assign redir_pc   = redir_target;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= BOOT;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_next    = pc_cur;
    pc_we      = 1'b0;
    flush      = 1'b0;
    halted     = 1'b0;
    trap       = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;

    case (state_q)
      BOOT: begin
        pc_next = RESET_PC;
        pc_we   = 1'b1;
        state_d = RUN;
      end

      RUN, FLUSH: begin
        flush = (state_q == FLUSH);
        if (halt_req) begin
          state_d = HALT;
        end else if (redirect) begin
          // A redirect inside FLUSH reloads the counter, stretching the window
          pc_next    = redir_pc;
          pc_we      = 1'b1;
          flush      = 1'b1;
          trap       = redir_trap;
          timer_load = 1'b1;
          state_d    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (!stall) begin
          pc_next = pc_seq;
          pc_we   = 1'b1;
          if (state_q == FLUSH) begin
            timer_dec = 1'b1;
            if (timer_done)
              state_d = RUN;
          end
        end
      end

      HALT: begin
        halted = 1'b1;
        if (resume && !halt_req) begin
          pc_next = pc_seq;
          pc_we   = 1'b1;
          state_d = RUN;
        end
      end

      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expected outputs, a negedge monitor checks.
// Expected trap behaviour follows PC_MISALIGN_TRAP_EN when the bench is built with it.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [63:0] pc_cur;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        jump;
  logic [63:0] jump_target;
  logic        stall;
  logic        halt_req;
  logic        resume;
  logic [63:0] pc_next;
  logic        pc_we;
  logic        flush;
  logic        halted;
  logic        trap;

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic        we;
    logic        fl;
    logic        hl;
    logic        tr;
    bit          ignorePc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] NA = 64'h0;

  pc_sequencer #(
    .XLEN         (64),
    .RESET_PC     (64'h0),
    .FLUSH_CYCLES (2),
    .TRAP_VECTOR  (64'h100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_cur        (pc_cur),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .stall         (stall),
    .halt_req      (halt_req),
    .resume        (resume),
    .pc_next       (pc_next),
    .pc_we         (pc_we),
    .flush         (flush),
    .halted        (halted),
    .trap          (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs just after the rising edge and queues what the outputs must be
  task automatic applyStimulus(
    input string       nm,
    input logic        rst,
    input logic [63:0] pcCur,
    input logic        br,
    input logic [63:0] brT,
    input logic        jp,
    input logic [63:0] jpT,
    input logic        st,
    input logic        hr,
    input logic        rs,
    input logic [63:0] ePc,
    input logic        eWe,
    input logic        eFl,
    input logic        eHl,
    input logic        eTr,
    input bit          ignPc
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    pc_cur        = pcCur;
    branch_taken  = br;
    branch_target = brT;
    jump          = jp;
    jump_target   = jpT;
    stall         = st;
    halt_req      = hr;
    resume        = rs;
    e.name     = nm;
    e.pc       = ePc;
    e.we       = eWe;
    e.fl       = eFl;
    e.hl       = eHl;
    e.tr       = eTr;
    e.ignorePc = ignPc;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    bit bad;
    bad = (pc_we !== e.we) || (flush !== e.fl) || (halted !== e.hl) || (trap !== e.tr) ||
          (!e.ignorePc && (pc_next !== e.pc));
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL %s: got pc_next=%h we=%b flush=%b halted=%b trap=%b, want pc_next=%h%s we=%b flush=%b halted=%b trap=%b",
               e.name, pc_next, pc_we, flush, halted, trap, e.pc, e.ignorePc ? "(any)" : "",
               e.we, e.fl, e.hl, e.tr);
    end
  endtask

  // Monitor: every queued expectation is compared on the falling edge of its cycle
  always @(negedge clk) begin
    if (expQ.size() != 0)
      checkOutput(expQ.pop_front());
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want run to finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] misTgt;
    logic        misTrap;
    reset = 1'b1; pc_cur = '0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; stall = 1'b0; halt_req = 1'b0; resume = 1'b0;

`ifdef PC_MISALIGN_TRAP_EN
    misTgt  = 64'h100;
    misTrap = 1'b1;
`else
    misTgt  = 64'h202;
    misTrap = 1'b0;
`endif

    //             name            rst pc_cur                 br brT     jp jpT     st hr rs  ePc                   we fl hl tr ign
    applyStimulus("reset0",        1, 64'h0,                 0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h0,                1, 0, 0, 0, 0);
    applyStimulus("reset1",        1, 64'h0,                 0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h0,                1, 0, 0, 0, 0);
    applyStimulus("reset2",        1, 64'h0,                 0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h0,                1, 0, 0, 0, 0);
    applyStimulus("boot",          0, 64'h0,                 0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h0,                1, 0, 0, 0, 0);
    applyStimulus("first_seq",     0, 64'h0,                 0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h4,                1, 0, 0, 0, 0);
    applyStimulus("branch",        0, 64'h20,                1, 64'h80, 0, 64'h0,  0, 0, 0, 64'h80,               1, 1, 0, 0, 0);
    applyStimulus("flush_tail",    0, 64'h80,                0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h84,               1, 1, 0, 0, 0);
    applyStimulus("flush_over",    0, 64'h84,                0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h88,               1, 0, 0, 0, 0);
    applyStimulus("jump_over_br",  0, 64'h88,                1, 64'h80, 1, 64'h200,0, 0, 0, 64'h200,              1, 1, 0, 0, 0);
    applyStimulus("flush_stall1",  0, 64'h200,               0, 64'h0,  0, 64'h0,  1, 0, 0, 64'h200,              0, 1, 0, 0, 0);
    applyStimulus("flush_stall2",  0, 64'h200,               0, 64'h0,  0, 64'h0,  1, 0, 0, 64'h200,              0, 1, 0, 0, 0);
    applyStimulus("flush_resume",  0, 64'h200,               0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h204,              1, 1, 0, 0, 0);
    applyStimulus("run_again",     0, 64'h204,               0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h208,              1, 0, 0, 0, 0);
    applyStimulus("run_stall",     0, 64'h208,               0, 64'h0,  0, 64'h0,  1, 0, 0, 64'h208,              0, 0, 0, 0, 0);
    applyStimulus("wrap",          0, 64'hFFFF_FFFF_FFFF_FFFC,0,64'h0,  0, 64'h0,  0, 0, 0, 64'h0,                1, 0, 0, 0, 0);
    applyStimulus("halt_req",      0, 64'h0,                 0, 64'h0,  0, 64'h0,  0, 1, 0, NA,                   0, 0, 0, 0, 1);
    applyStimulus("halt_ignore",   0, 64'h40,                1, 64'h80, 1, 64'h300,1, 0, 0, NA,                   0, 0, 1, 0, 1);
    applyStimulus("halt_both",     0, 64'h40,                0, 64'h0,  0, 64'h0,  0, 1, 1, NA,                   0, 0, 1, 0, 1);
    applyStimulus("resume",        0, 64'h40,                0, 64'h0,  0, 64'h0,  0, 0, 1, 64'h44,               1, 0, 1, 0, 0);
    applyStimulus("after_resume",  0, 64'h44,                0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h48,               1, 0, 0, 0, 0);
    applyStimulus("misaligned_jmp",0, 64'h48,                0, 64'h0,  1, 64'h202,0, 0, 0, misTgt,               1, 1, 0, misTrap, 0);
    applyStimulus("redirect_in_fl",0, misTgt,                1, 64'h300,0, 64'h0,  0, 0, 0, 64'h300,              1, 1, 0, 0, 0);
    applyStimulus("extended_tail", 0, 64'h300,               0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h304,              1, 1, 0, 0, 0);
    applyStimulus("window_end",    0, 64'h304,               1, 64'h400,0, 64'h0,  0, 0, 0, 64'h400,              1, 1, 0, 0, 0);
    applyStimulus("reset_in_flush",1, 64'h400,               0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h0,                1, 0, 0, 0, 0);
    applyStimulus("reboot",        0, 64'h400,               0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h0,                1, 0, 0, 0, 0);
    applyStimulus("reboot_seq",    0, 64'h0,                 0, 64'h0,  0, 64'h0,  0, 0, 0, 64'h4,                1, 0, 0, 0, 0);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d unchecked entries, want 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
